// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory refill/writeback port between icache and dcache; define ARB_RR_EN for round-robin tie-break (default: dcache wins ties)
module cache_mem_arbiter #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rd_req,
  input  logic [2:0]           i_rd_type,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic                 i_rd_rdy,
  output logic                 i_ret_valid,
  output logic                 i_ret_last,
  output logic [31:0]          i_ret_data,
  input  logic                 d_rd_req,
  input  logic [2:0]           d_rd_type,
  input  logic [ADDR_W-1:0]    d_rd_addr,
  output logic                 d_rd_rdy,
  output logic                 d_ret_valid,
  output logic                 d_ret_last,
  output logic [31:0]          d_ret_data,
  input  logic                 d_wr_req,
  input  logic [2:0]           d_wr_type,
  input  logic [ADDR_W-1:0]    d_wr_addr,
  input  logic [3:0]           d_wr_wstrb,
  input  logic [LINE_BITS-1:0] d_wr_data,
  output logic                 d_wr_rdy,
  output logic                 m_rd_req,
  output logic [2:0]           m_rd_type,
  output logic [ADDR_W-1:0]    m_rd_addr,
  input  logic                 m_rd_rdy,
  input  logic                 m_ret_valid,
  input  logic                 m_ret_last,
  input  logic [31:0]          m_ret_data,
  output logic                 m_wr_req,
  output logic [2:0]           m_wr_type,
  output logic [ADDR_W-1:0]    m_wr_addr,
  output logic [3:0]           m_wr_wstrb,
  output logic [LINE_BITS-1:0] m_wr_data,
  input  logic                 m_wr_rdy
);
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rd_state_t;
  typedef enum logic {W_EMPTY, W_FULL} wr_state_t;
  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic                 grant_d;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [2:0]           rd_type_q;
  logic [2:0]           wb_type;
  logic [ADDR_W-1:0]    wb_addr;
  logic [3:0]           wb_strb;
  logic [LINE_BITS-1:0] wb_data;
  logic wb_full, i_elig, d_elig, pick_d, start, run, in_wait;
  assign run = !reset;
  assign wb_full = wr_state == W_FULL;
  assign i_elig = i_rd_req && !(wb_full && i_rd_addr[ADDR_W-1:4] == wb_addr[ADDR_W-1:4]);
  assign d_elig = d_rd_req && !(wb_full && d_rd_addr[ADDR_W-1:4] == wb_addr[ADDR_W-1:4]);
  assign start = rd_state == R_IDLE && (i_elig || d_elig);
`ifdef ARB_RR_EN
  logic last_d;
  assign pick_d = d_elig && (!i_elig || !last_d);
  // remember the previous winner so a tie goes to the other cache
  always_ff @(posedge clk)
    if (reset) last_d <= 1'b0;
    else if (start) last_d <= pick_d;
`else
  assign pick_d = d_elig;
`endif
  // read FSM state and latched winner/request
  always_ff @(posedge clk)
    if (reset) begin
      rd_state <= R_IDLE;
      grant_d <= 1'b0;
      rd_addr_q <= '0;
      rd_type_q <= '0;
    end else begin
      rd_state <= rd_next;
      if (start) begin
        grant_d <= pick_d;
        rd_addr_q <= pick_d ? d_rd_addr : i_rd_addr;
        rd_type_q <= pick_d ? d_rd_type : i_rd_type;
      end
    end
  // read FSM next state
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: rd_next = start ? R_REQ : R_IDLE;
      R_REQ:  rd_next = m_rd_rdy ? R_WAIT : R_REQ;
      R_WAIT: rd_next = (m_ret_valid && m_ret_last) ? R_IDLE : R_WAIT;
      default: rd_next = R_IDLE;
    endcase
  end
  // write buffer state and captured writeback
  always_ff @(posedge clk)
    if (reset) begin
      wr_state <= W_EMPTY;
      wb_type <= '0;
      wb_addr <= '0;
      wb_strb <= '0;
      wb_data <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_state == W_EMPTY && d_wr_req) begin
        wb_type <= d_wr_type;
        wb_addr <= d_wr_addr;
        wb_strb <= d_wr_wstrb;
        wb_data <= d_wr_data;
      end
    end
  // write buffer next state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_EMPTY: wr_next = d_wr_req ? W_FULL : W_EMPTY;
      W_FULL:  wr_next = m_wr_rdy ? W_EMPTY : W_FULL;
      default: wr_next = W_EMPTY;
    endcase
  end
  // outputs, all forced low while reset is held; return beats pass straight to the winner
  always_comb begin
    in_wait = run && rd_state == R_WAIT;
    m_rd_req = run && rd_state == R_REQ;
    m_rd_addr = run ? rd_addr_q : '0;
    m_rd_type = run ? rd_type_q : '0;
    i_rd_rdy = m_rd_req && !grant_d && m_rd_rdy;
    d_rd_rdy = m_rd_req && grant_d && m_rd_rdy;
    i_ret_valid = in_wait && !grant_d && m_ret_valid;
    i_ret_last = in_wait && !grant_d && m_ret_valid && m_ret_last;
    i_ret_data = (in_wait && !grant_d) ? m_ret_data : '0;
    d_ret_valid = in_wait && grant_d && m_ret_valid;
    d_ret_last = in_wait && grant_d && m_ret_valid && m_ret_last;
    d_ret_data = (in_wait && grant_d) ? m_ret_data : '0;
    d_wr_rdy = run && wr_state == W_EMPTY;
    m_wr_req = run && wb_full;
    m_wr_type = run ? wb_type : '0;
    m_wr_addr = run ? wb_addr : '0;
    m_wr_wstrb = run ? wb_strb : '0;
    m_wr_data = run ? wb_data : '0;
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter with directed refill, tie, writeback, hazard and reset scenarios
module tb_cache_mem_arbiter;
  logic clk, reset;
  logic i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
  logic [2:0] i_rd_type, d_rd_type, d_wr_type, m_rd_type, m_wr_type;
  logic [31:0] i_rd_addr, d_rd_addr, d_wr_addr, m_rd_addr, m_wr_addr;
  logic [31:0] i_ret_data, d_ret_data, m_ret_data;
  logic d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last, d_wr_req, d_wr_rdy;
  logic [3:0] d_wr_wstrb, m_wr_wstrb;
  logic [127:0] d_wr_data, m_wr_data;
  logic m_rd_req, m_rd_rdy, m_ret_valid, m_ret_last, m_wr_req, m_wr_rdy;
  int pass_n = 0, tot_n = 0, c;
  logic [31:0] b2, b3;
  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] sel;
    logic [31:0] a;
    logic last;
    logic [2:0] typ;
    logic [3:0] strb;
    logic [127:0] wd;
  } ev_t;
  ev_t q[$];
  cache_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
    .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr), .m_wr_wstrb(m_wr_wstrb),
    .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask
  task automatic ev(input ev_t o);
    ev_t e;
    tot_n++;
    if (q.size() == 0) $display("FAIL unexpected_event kind=%0d a=%h sel=%b", o.kind, o.a, o.sel);
    else begin
      e = q.pop_front();
      if (o === e) pass_n++;
      else $display("FAIL event got kind=%0d sel=%b a=%h last=%b typ=%h strb=%h wd=%h exp kind=%0d sel=%b a=%h last=%b typ=%h strb=%h wd=%h",
                    o.kind, o.sel, o.a, o.last, o.typ, o.strb, o.wd, e.kind, e.sel, e.a, e.last, e.typ, e.strb, e.wd);
    end
  endtask
  // monitor: every observable transfer pops and checks the next expected event
  always @(negedge clk) begin
    ev_t o;
    if (m_rd_req && m_rd_rdy) begin
      o = '0; o.kind = 2'd0; o.sel = {i_rd_rdy, d_rd_rdy}; o.a = m_rd_addr; o.typ = m_rd_type; ev(o);
    end
    if (i_ret_valid) begin
      o = '0; o.kind = 2'd1; o.a = i_ret_data; o.last = i_ret_last; ev(o);
    end
    if (d_ret_valid) begin
      o = '0; o.kind = 2'd2; o.a = d_ret_data; o.last = d_ret_last; ev(o);
    end
    if (m_wr_req && m_wr_rdy) begin
      o = '0; o.kind = 2'd3; o.a = m_wr_addr; o.typ = m_wr_type; o.strb = m_wr_wstrb; o.wd = m_wr_data; ev(o);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic push_rd(input logic d, input logic [31:0] a);
    ev_t e;
    e = '0; e.kind = 2'd0; e.sel = d ? 2'b01 : 2'b10; e.a = a; e.typ = 3'b100;
    q.push_back(e);
  endtask
  task automatic push_beats(input logic d, input logic [31:0] base, input int n);
    ev_t e;
    for (int k = 0; k < n; k++) begin
      e = '0; e.kind = d ? 2'd2 : 2'd1; e.a = base + (k + 1) * 32'h11; e.last = (k == 3);
      q.push_back(e);
    end
  endtask
  task automatic push_wr(input logic [31:0] a, input logic [127:0] wd);
    ev_t e;
    e = '0; e.kind = 2'd3; e.a = a; e.typ = 3'b100; e.strb = 4'hF; e.wd = wd;
    q.push_back(e);
  endtask
  task automatic beats(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      m_ret_valid = 1; m_ret_data = base + (k + 1) * 32'h11; m_ret_last = (k == 3);
      cyc();
    end
    m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
  endtask
  task automatic wait_grant(output int cnt);
    logic gi, gd;
    for (int w = 0; w < 20; w++) begin
      smp();
      if (m_rd_req && m_rd_rdy) begin
        gi = i_rd_rdy; gd = d_rd_rdy;
        cyc();
        if (gi) i_rd_req = 0;
        if (gd) d_rd_req = 0;
        cnt = w;
        return;
      end
    end
    tot_n++;
    $display("FAIL grant_timeout got=no m_rd_req exp=grant within 20 cycles");
    cnt = 99;
    cyc();
  endtask
  initial begin
    reset = 1; i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    i_rd_type = 3'b100; d_rd_type = 3'b100; d_wr_type = 3'b100; d_wr_wstrb = 4'hF;
    i_rd_addr = 0; d_rd_addr = 0; d_wr_addr = 0; d_wr_data = 0;
    m_rd_rdy = 1; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0; m_wr_rdy = 0;
    repeat (3) cyc();
    smp();
    chk("rst_m_rd_req", m_rd_req, 0);
    chk("rst_d_wr_rdy", d_wr_rdy, 0);
    chk("rst_m_wr_req", m_wr_req, 0);
    cyc(); reset = 0;
    smp();
    chk("post_rst_d_wr_rdy", d_wr_rdy, 1);
    // single icache refill
    cyc();
    push_rd(0, 32'h1C000040); push_beats(0, 32'h0, 4);
    i_rd_req = 1; i_rd_addr = 32'h1C000040;
    smp();
    chk("t1_no_req_same_cycle", m_rd_req, 0);
    wait_grant(c);
    chk("t1_req_latency", c, 0);
    beats(32'h0, 4);
    // stray return beat while idle must be dropped
    m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'hBAD;
    smp();
    chk("stray_i_ret", i_ret_valid, 0);
    chk("stray_d_ret", d_ret_valid, 0);
    cyc(); m_ret_valid = 0; m_ret_last = 0;
    smp();
    chk("stray_still_idle", m_rd_req, 0);
    // two consecutive ties
    cyc();
    push_rd(1, 32'h5000); push_beats(1, 32'hD0, 4);
`ifdef ARB_RR_EN
    push_rd(0, 32'h6000); push_beats(0, 32'h100, 4);
    push_rd(1, 32'h5040); push_beats(1, 32'h200, 4);
    b2 = 32'h100; b3 = 32'h200;
`else
    push_rd(1, 32'h5040); push_beats(1, 32'h200, 4);
    push_rd(0, 32'h6000); push_beats(0, 32'h100, 4);
    b2 = 32'h200; b3 = 32'h100;
`endif
    i_rd_req = 1; i_rd_addr = 32'h6000; d_rd_req = 1; d_rd_addr = 32'h5000;
    wait_grant(c);
    d_rd_req = 1; d_rd_addr = 32'h5040;
    beats(32'hD0, 4);
    wait_grant(c);
    chk("t2_second_tie_latency", c, 1);
    beats(b2, 4);
    wait_grant(c);
    beats(b3, 4);
    // writeback with memory stalling five cycles
    d_wr_req = 1; d_wr_addr = 32'h00001000; d_wr_data = {4{32'hA5A5A5A5}};
    smp();
    chk("t3_wr_rdy_before", d_wr_rdy, 1);
    cyc(); d_wr_req = 0;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t3_wr_rdy_stall", d_wr_rdy, 0);
      chk("t3_m_wr_req_stall", m_wr_req, 1);
      cyc();
    end
    push_wr(32'h00001000, {4{32'hA5A5A5A5}});
    m_wr_rdy = 1;
    smp();
    cyc(); m_wr_rdy = 0;
    smp();
    chk("t3_wr_rdy_after", d_wr_rdy, 1);
    chk("t3_m_wr_req_after", m_wr_req, 0);
    // hazard: dcache read to buffered line waits, icache read proceeds
    cyc();
    d_wr_req = 1; d_wr_addr = 32'h00001000; d_wr_data = {4{32'h5A5A5A5A}};
    cyc(); d_wr_req = 0;
    push_rd(0, 32'h2000); push_beats(0, 32'h300, 4);
    d_rd_req = 1; d_rd_addr = 32'h00001008; i_rd_req = 1; i_rd_addr = 32'h00002000;
    wait_grant(c);
    chk("t4_icache_latency", c, 1);
    beats(32'h300, 4);
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("t4_hazard_stall", m_rd_req, 0);
      cyc();
    end
    push_wr(32'h00001000, {4{32'h5A5A5A5A}});
    m_wr_rdy = 1;
    smp();
    chk("t4_stall_drain_cycle", m_rd_req, 0);
    cyc(); m_wr_rdy = 0;
    push_rd(1, 32'h00001008); push_beats(1, 32'h400, 4);
    smp();
    chk("t4_stall_release_cycle", m_rd_req, 0);
    cyc();
    smp();
    chk("t4_d_req_after_drain", m_rd_req, 1);
    cyc(); d_rd_req = 0;
    beats(32'h400, 4);
    // reset in the middle of a burst with a write buffered
    d_wr_req = 1; d_wr_addr = 32'h7000; d_wr_data = {4{32'h77777777}};
    cyc(); d_wr_req = 0;
    push_rd(1, 32'h3000); push_beats(1, 32'h500, 2);
    d_rd_req = 1; d_rd_addr = 32'h3000;
    wait_grant(c);
    beats(32'h500, 2);
    reset = 1; m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'h999;
    for (int k = 0; k < 2; k++) begin
      smp();
      chk("t5_rst_m_rd_req", m_rd_req, 0);
      chk("t5_rst_rdy", {i_rd_rdy, d_rd_rdy, d_wr_rdy}, 0);
      chk("t5_rst_ret", {i_ret_valid, i_ret_last, d_ret_valid, d_ret_last}, 0);
      chk("t5_rst_ret_data", {i_ret_data, d_ret_data}, 0);
      chk("t5_rst_m_wr", {m_wr_req, m_wr_addr}, 0);
      cyc();
    end
    reset = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
    smp();
    chk("t5_wr_rdy_after_rst", d_wr_rdy, 1);
    chk("t5_write_dropped", m_wr_req, 0);
    cyc();
    push_rd(1, 32'h4000); push_beats(1, 32'h600, 4);
    d_rd_req = 1; d_rd_addr = 32'h4000;
    wait_grant(c);
    chk("t5_new_req_latency", c, 1);
    beats(32'h600, 4);
    repeat (3) cyc();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one memory-side refill/writeback port between the instruction cache and the data cache. It arbitrates line-refill read requests from both caches and routes the returned beats to the winner. It also holds one dirty-line writeback from the data cache in a single-entry write buffer. Reads that hit the buffered line are stalled until the buffer drains. The block sits between the two cache instances and the AXI bridge.

## Interface
Parameters:
- LINE_BITS, 128, cache-line width in bits; also the width of the wr_data ports.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_rd_req, i_rd_type[3], i_rd_addr[ADDR_W]  in  icache refill request.
- i_rd_rdy  out  1  icache request accepted.
- i_ret_valid, i_ret_last  out  1  icache return beat strobes.
- i_ret_data  out  32  icache return beat data.
- d_rd_req, d_rd_type[3], d_rd_addr[ADDR_W]  in  dcache refill request.
- d_rd_rdy, d_ret_valid, d_ret_last  out  1  dcache read handshake and return strobes.
- d_ret_data  out  32  dcache return beat data.
- d_wr_req, d_wr_type[3], d_wr_addr[ADDR_W], d_wr_wstrb[4], d_wr_data[LINE_BITS]  in  dcache writeback request.
- d_wr_rdy  out  1  write buffer empty.
- m_rd_req, m_rd_type[3], m_rd_addr[ADDR_W]  out  memory read request.
- m_rd_rdy, m_ret_valid, m_ret_last  in  1  memory read handshake and return strobes.
- m_ret_data  in  32  memory return beat data.
- m_wr_req, m_wr_type[3], m_wr_addr[ADDR_W], m_wr_wstrb[4], m_wr_data[LINE_BITS]  out  memory write request.
- m_wr_rdy  in  1  memory accepts write.

## Operation
- Read FSM states:
  - R_IDLE: evaluate eligible requesters. A requester is eligible if its rd_req=1 and it is not blocked by the hazard rule. Latch the winner's grant, addr and type, then go to R_REQ. With no eligible requester, stay in R_IDLE.
  - R_REQ: drive m_rd_req=1 with the latched addr and type. The winner's rd_rdy equals m_rd_rdy combinationally. On m_rd_rdy go to R_WAIT.
  - R_WAIT: route m_ret_valid, m_ret_last and m_ret_data to the winner. The loser's ret_valid and ret_last are 0. On m_ret_valid&&m_ret_last go to R_IDLE.
- Requesters must hold rd_req and addr stable until their rd_rdy. A non-granted requester sees rd_rdy=0.
- Hazard rule: while the write buffer is full, a read whose addr[ADDR_W-1:4] equals the buffered addr[ADDR_W-1:4] is not eligible. This applies to both caches.
- Tie (both caches eligible in R_IDLE): resolved by the policy under Configuration.
- Write buffer FSM:
  - W_EMPTY: d_wr_rdy=1. When d_wr_req=1, capture type, addr, wstrb and data, then go to W_FULL.
  - W_FULL: d_wr_rdy=0 and m_wr_req=1 with the buffered fields. On m_wr_rdy go to W_EMPTY.
- The write and read channels run independently. A read to a line other than the buffered one may proceed while the buffer is full.
- Returned data is never buffered; beats pass straight through.

## Timing
- Reset values:
  - Both FSMs idle/empty; buffer contents 0.
  - All req, rdy, ret and m_* outputs 0 while reset is asserted.
  - d_wr_rdy=1 from the first cycle after reset deasserts.
- Read path latency: rd_req asserted in cycle N (eligible, R_IDLE) → m_rd_req asserted in N+1.
- Return path latency: zero-cycle passthrough.
- After ret_last, the earliest next m_rd_req is 2 cycles later (R_IDLE, then R_REQ).
- Write path latency: d_wr_req captured in cycle N → m_wr_req asserted in N+1. After m_wr_rdy in cycle M, d_wr_rdy=1 in M+1.
- A hazard stall releases in the cycle after W_FULL→W_EMPTY. The blocked read then enters arbitration normally.
- m_ret_valid while in R_IDLE or R_REQ (a protocol violation): ignored, with nothing forwarded.
- Reset mid-burst: FSMs return to idle and the buffered write is dropped.
- Type widths: rd_type and wr_type are passed unmodified. wstrb is meaningful only for non-line writes.

## Configuration
- ARB_RR_EN defined: round-robin tie-break.
  - A last_grant register records the previous winner; on a tie the other cache wins.
  - After reset, last_grant=icache, so dcache wins the first tie.
- ARB_RR_EN undefined: fixed priority; dcache always wins a tie. The last_grant register is not built.

## Test plan
- Single icache refill, addr 0x1C000040:
  - m_rd_req one cycle after i_rd_req, addr 0x1C000040.
  - 4 beats 0x11,0x22,0x33,0x44 appear on i_ret_data with i_ret_last on the 4th.
  - d_ret_valid stays 0 throughout.
- Simultaneous i_rd_req and d_rd_req, repeated twice:
  - fixed-priority build: dcache granted both times.
  - ARB_RR_EN build: dcache first, icache second.
- Dcache writeback to 0x00001000 with data 128'hA5…, m_wr_rdy held 0 for 5 cycles:
  - d_wr_rdy=0 and m_wr_req=1 for those cycles.
  - d_wr_rdy returns to 1 the cycle after m_wr_rdy.
- Buffer holds 0x00001000 and d_rd_req to 0x00001008:
  - no m_rd_req until the buffer drains.
  - a concurrent i_rd_req to 0x00002000 is granted meanwhile.
- Reset asserted after 2 of 4 return beats:
  - all outputs 0 during reset.
  - d_wr_rdy=1 the cycle after reset deasserts.
  - a new d_rd_req is serviced normally afterwards.
